// File: rtl/mux_rr_n_pkg.sv
// Shared definitions for the mux_rr_n channel multiplexer: mode encodings and
// the wrap-around index increment used by the round-robin pointer.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_n_if.sv
// Handshake bundle between N upstream channels, the mux and one downstream
// consumer; the slave modport is the mux side.
interface mux_rr_n_if #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
);

    logic [N*W-1:0] data_in;
    logic [N-1:0]   valid_in;
    logic [N-1:0]   ready_in;
    logic [SW-1:0]  S;
    logic           mode;
    logic [W-1:0]   Q;
    logic           valid_out;
    logic           ready_out;
    logic [SW-1:0]  sel_out;

    modport master (
        output data_in, valid_in, S, mode, ready_out,
        input  ready_in, Q, valid_out, sel_out
    );

    modport slave (
        input  data_in, valid_in, S, mode, ready_out,
        output ready_in, Q, valid_out, sel_out
    );

endinterface

// File: rtl/mux_rr_n_rr_pick.sv
// Rotating-priority finder: returns the first valid channel scanning from
// ptr_i upward with wrap, plus a flag telling whether any channel was valid.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [SW-1:0] ptr_i,
    output logic          found_o,
    output logic [SW-1:0] idx_o
);

    int            cand;
    logic [SW-1:0] candIdx;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) cand = cand - N;
            candIdx = SW'(cand);
            if (!found_o && valid_i[candIdx]) begin
                found_o = 1'b1;
                idx_o   = candIdx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered mux with valid/ready on both sides and back-pressure.
// Define MUX_RR_MODE_EN to add round-robin auto-select (mode = 1) and its pointer.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int W  = 4,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input logic        clk,
    input logic        Reset_L,
    mux_rr_n_if.slave  bus
);

    logic          load;
    logic          selOk;
    logic          grantOk;
    logic [SW-1:0] gIdx;
    logic          xfer;
    logic [N-1:0]  readyIn;
    logic [W-1:0]  curData;

    logic [W-1:0]  q_q,     q_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] sel_q,   sel_d;

    // Explicit select is only a grant when it names an existing channel.
    assign selOk = (32'(bus.S) < N);

`ifdef MUX_RR_MODE_EN
    logic          rrFound;
    logic [SW-1:0] rrIdx;
    logic [SW-1:0] ptr_q, ptr_d;

    rr_pick #(.N(N), .SW(SW)) uPick (
        .valid_i (bus.valid_in),
        .ptr_i   (ptr_q),
        .found_o (rrFound),
        .idx_o   (rrIdx)
    );

    always_comb begin
        grantOk = selOk;
        gIdx    = bus.S;
        if (bus.mode == MODE_RR) begin
            grantOk = rrFound;
            gIdx    = rrIdx;
        end
    end

    // The pointer only advances on round-robin transfers, so explicit mode leaves it parked.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && bus.mode == MODE_RR) ptr_d = SW'(next_idx(int'(gIdx), N));
    end

    always_ff @(posedge clk or negedge Reset_L) begin
        if (!Reset_L) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    logic unusedMode;
    assign unusedMode = bus.mode;
    assign grantOk    = selOk;
    assign gIdx       = bus.S;
`endif

    assign load    = !valid_q || bus.ready_out;
    assign xfer    = Reset_L && load && grantOk && bus.valid_in[gIdx];
    assign curData = bus.data_in[int'(gIdx)*W +: W];

    always_comb begin
        readyIn = '0;
        if (Reset_L && load && grantOk) readyIn[gIdx] = 1'b1;
    end

    // A free output stage either takes the new word or drops valid; Q/sel keep the last word.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (load) begin
            valid_d = xfer;
            if (xfer) begin
                q_d   = curData;
                sel_d = gIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_L) begin
        if (!Reset_L) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.ready_in  = readyIn;
    assign bus.Q         = q_q;
    assign bus.valid_out = valid_q;
    assign bus.sel_out   = sel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n (W=4, N=4): directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_mux_rr_n;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk     = 1'b0;
    logic Reset_L = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    // Reference state: the word held by the output stage plus the scan pointer.
    logic [W-1:0] mQ;
    logic         mValid;
    int           mSel;
    int           mPtr;

    always #5 clk = ~clk;

    mux_rr_n_if #(.W(W), .N(N)) bus ();

    mux_rr_n #(.W(W), .N(N)) dut (
        .clk     (clk),
        .Reset_L (Reset_L),
        .bus     (bus.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mQ     = '0;
        mValid = 1'b0;
        mSel   = 0;
        mPtr   = 0;
    endtask

    task automatic modelGrant(output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
`ifdef MUX_RR_MODE_EN
        if (bus.mode) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mPtr + k) % N;
                if (!ok && bus.valid_in[c]) begin
                    ok = 1'b1;
                    g  = c;
                end
            end
            return;
        end
`endif
        g  = int'(bus.S);
        ok = (g < N);
    endtask

    task automatic applyStimulus(input logic [N*W-1:0] d, input logic [N-1:0] v,
                                 input logic [SW-1:0] s, input logic m, input logic ro);
        bit           load;
        bit           ok;
        bit           xfer;
        int           g;
        logic [N-1:0] expReady;
        @(negedge clk);
        bus.data_in   = d;
        bus.valid_in  = v;
        bus.S         = s;
        bus.mode      = m;
        bus.ready_out = ro;
        #1;
        load = !mValid || ro;
        modelGrant(ok, g);
        expReady = '0;
        if (load && ok) expReady[g] = 1'b1;
        checkOutput("ready_in", 32'(bus.ready_in), 32'(expReady));
        xfer = load && ok && v[g];
        @(posedge clk);
        #1;
        if (load) begin
            mValid = xfer;
            if (xfer) begin
                mQ   = d[g*W +: W];
                mSel = g;
`ifdef MUX_RR_MODE_EN
                if (m) mPtr = (g + 1) % N;
`endif
            end
        end
        checkOutput("Q", 32'(bus.Q), 32'(mQ));
        checkOutput("valid_out", 32'(bus.valid_out), 32'(mValid));
        checkOutput("sel_out", 32'(bus.sel_out), 32'(mSel));
    endtask

    initial begin
        logic [N*W-1:0] rrData;
        int             rrSel [5];
        logic           curMode;

        bus.data_in   = '0;
        bus.valid_in  = '1;
        bus.S         = '0;
        bus.mode      = 1'b0;
        bus.ready_out = 1'b1;
        modelReset();

        // Held in reset: outputs cleared and no channel is offered a slot.
        #12;
        checkOutput("rst_Q", 32'(bus.Q), 32'h0);
        checkOutput("rst_valid", 32'(bus.valid_out), 32'h0);
        checkOutput("rst_sel", 32'(bus.sel_out), 32'h0);
        checkOutput("rst_ready_in", 32'(bus.ready_in), 32'h0);
        @(negedge clk);
        Reset_L = 1'b1;

        // Explicit select of channel 2.
        applyStimulus(16'h0600, 4'b0100, 2'd2, 1'b0, 1'b1);
        checkOutput("explicit_Q", 32'(bus.Q), 32'h6);
        checkOutput("explicit_sel", 32'(bus.sel_out), 32'h2);

        // Back-pressure with every channel valid, then release.
        for (int i = 0; i < 3; i++) applyStimulus(16'h4321, 4'b1111, 2'd3, 1'b0, 1'b0);
        checkOutput("bp_Q_held", 32'(bus.Q), 32'h6);
        applyStimulus(16'h4321, 4'b1111, 2'd3, 1'b0, 1'b1);
        checkOutput("bp_release_Q", 32'(bus.Q), 32'h4);

        // Load 4'hA, stall it, then assert reset between clock edges.
        applyStimulus(16'h00A0, 4'b0010, 2'd1, 1'b0, 1'b1);
        applyStimulus(16'h00A0, 4'b0010, 2'd1, 1'b0, 1'b0);
        checkOutput("pre_rst_Q", 32'(bus.Q), 32'hA);
        #2;
        Reset_L = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_Q", 32'(bus.Q), 32'h0);
        checkOutput("async_rst_valid", 32'(bus.valid_out), 32'h0);
        checkOutput("async_rst_sel", 32'(bus.sel_out), 32'h0);
        checkOutput("async_rst_ready_in", 32'(bus.ready_in), 32'h0);
        @(negedge clk);
        Reset_L = 1'b1;

        // Round-robin fairness; without the feature the mux stays on S = 1.
        rrData = {4'hB, 4'hA, 4'h9, 4'h8};
`ifdef MUX_RR_MODE_EN
        rrSel = '{0, 1, 2, 3, 0};
`else
        rrSel = '{1, 1, 1, 1, 1};
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rrData, 4'b1111, 2'd1, 1'b1, 1'b1);
            checkOutput("rr_sel", 32'(bus.sel_out), 32'(rrSel[i]));
            checkOutput("rr_Q", 32'(bus.Q), 32'(rrSel[i] + 8));
        end

        // Pointer wrap and skip of idle channels, then a fully idle cycle.
        applyStimulus(rrData, 4'b0100, 2'd1, 1'b1, 1'b1);
        applyStimulus(rrData, 4'b0010, 2'd1, 1'b1, 1'b1);
        applyStimulus(rrData, 4'b0000, 2'd1, 1'b1, 1'b1);
        checkOutput("idle_valid", 32'(bus.valid_out), 32'h0);
        applyStimulus(rrData, 4'b1111, 2'd1, 1'b1, 1'b1);

        // Random traffic with occasional mode flips and downstream stalls.
        curMode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) curMode = ~curMode;
            applyStimulus(16'($urandom), 4'($urandom), 2'($urandom), curMode,
                          $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
